// File: rtl/ram_param_unit_pkg.sv
// Shared types and default widths for the parametrised CPU RAM.
package ram_pkg;

  localparam int unsigned RAM_DW = 8;
  localparam int unsigned RAM_AW = 8;

  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_t;

  // Last address of a 2**aw deep memory (all ones), used as the clear terminal count.
  function automatic logic [31:0] ram_last_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/ram_param_unit_core.sv
// Single-port storage array: synchronous write, registered read, no reset.
module ram_core_sp #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port and registered read share one address; the owner never asserts both.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_param_unit.sv
// CPU RAM with MAR, manual front-panel entry, registered read strobe and
// a whole-memory clear sequencer.
module ram_param_unit
  import ram_pkg::*;
#(
  parameter int unsigned   DW       = RAM_DW,
  parameter int unsigned   AW       = RAM_AW,
  parameter int unsigned   AUTO_INC = 1,
  parameter logic [DW-1:0] CLR_VAL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cpu_bus,
  input  logic [DW-1:0] Fi,
  input  logic          MW,
  input  logic          A_D,
  input  logic          CU_in,
  input  logic          WR,
  input  logic          RD,
  input  logic          ST,
  input  logic          clr,
  output logic [DW-1:0] CPU_BUS,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] mar_out
);

  localparam logic [AW-1:0] CNT_LAST = AW'(ram_last_addr(AW));

  ram_state_t    state;
  logic [AW-1:0] mar;
  logic [AW-1:0] cnt;
  logic          st_q;

  logic [DW-1:0] src;
  logic          st_rise;
  logic          clearing;
  logic          cmd_ok;
  logic          mar_ld;
  logic          man_wr;
  logic          cpu_wr;
  logic          cpu_rd;

  logic          core_we;
  logic          core_re;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;

  // Command decode; a clr pulse in IDLE suppresses every other command that cycle.
  always_comb begin
    src      = MW ? Fi : cpu_bus;
    st_rise  = ST & ~st_q;
    clearing = (state == RAM_CLEAR);
    cmd_ok   = (state == RAM_IDLE) & ~clr;
    mar_ld   = cmd_ok & A_D & (MW ? st_rise : CU_in);
    man_wr   = cmd_ok & MW & ~A_D & st_rise;
    cpu_wr   = cmd_ok & ~MW & ~A_D & WR;
    cpu_rd   = cmd_ok & ~MW & RD & ~WR;
  end

  // Core port steering: the clear counter owns the array while clearing, MAR otherwise.
  // Writes are gated by rst so a reset during a clear stops it on that very edge.
  always_comb begin
    core_we    = ~rst & (clearing | man_wr | cpu_wr);
    core_re    = ~rst & cpu_rd;
    core_addr  = clearing ? cnt : mar;
    core_wdata = clearing ? CLR_VAL : src;
  end

  ram_core_sp #(
    .DW(DW),
    .AW(AW)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .re   (core_re),
    .addr (core_addr),
    .wdata(core_wdata),
    .rdata(core_rdata)
  );

  // MAR, edge detector, read strobe and clear sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RAM_IDLE;
      mar      <= '0;
      cnt      <= '0;
      st_q     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      st_q     <= ST;
      rd_valid <= cpu_rd;
      case (state)
        RAM_IDLE: begin
          if (clr) begin
            state <= RAM_CLEAR;
            cnt   <= '0;
          end else if (mar_ld) begin
            mar <= src[AW-1:0];
          end else if (man_wr && (AUTO_INC != 0)) begin
            mar <= mar + 1'b1;
          end
        end
        RAM_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= RAM_IDLE;
          end
        end
        default: state <= RAM_IDLE;
      endcase
    end
  end

  // Output staging: read data is only driven onto the bus while it is valid.
  always_comb begin
    CPU_BUS = rd_valid ? core_rdata : '0;
    busy    = (state == RAM_CLEAR);
    mar_out = mar;
  end

endmodule

// File: tb/tb_ram_param_unit.sv
// Bench for ram_param_unit: directed vector table, hand-written clear/reset
// sequences, and random traffic checked against a behavioural model.
module tb_ram_param_unit;

  logic       clk = 1'b0;
  logic       rst, mw, ad, cu, wr, rd, st, clr;
  logic [7:0] bus, fi;

  logic [7:0] cb0, cb1, mo0, mo1;
  logic       rv0, rv1, by0, by1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_param_unit #(.DW(8), .AW(8), .AUTO_INC(1), .CLR_VAL(8'h00)) u0 (
    .clk(clk), .rst(rst), .cpu_bus(bus), .Fi(fi), .MW(mw), .A_D(ad), .CU_in(cu),
    .WR(wr), .RD(rd), .ST(st), .clr(clr),
    .CPU_BUS(cb0), .rd_valid(rv0), .busy(by0), .mar_out(mo0)
  );

  ram_param_unit #(.DW(8), .AW(8), .AUTO_INC(0), .CLR_VAL(8'hC3)) u1 (
    .clk(clk), .rst(rst), .cpu_bus(bus), .Fi(fi), .MW(mw), .A_D(ad), .CU_in(cu),
    .WR(wr), .RD(rd), .ST(st), .clr(clr),
    .CPU_BUS(cb1), .rd_valid(rv1), .busy(by1), .mar_out(mo1)
  );

  // ---------------- behavioural model (index 0 = u0, 1 = u1) ----------------
  logic [7:0] m_mem [2][256];
  logic [7:0] m_mar [2];
  logic [7:0] m_rdd [2];
  bit         m_rdv [2];
  bit         m_stq;
  int         m_clr_left;
  int         m_clr_pos;

  task automatic model_step();
    bit         rise;
    logic [7:0] a;
    logic [7:0] cv;
    rise = st && !m_stq;
    if (rst) begin
      m_stq = 0;
      m_clr_left = 0;
      for (int i = 0; i < 2; i++) begin
        m_mar[i] = 8'h00;
        m_rdv[i] = 0;
      end
    end else begin
      m_stq = st;
      if (m_clr_left > 0) begin
        for (int i = 0; i < 2; i++) begin
          cv = (i == 0) ? 8'h00 : 8'hC3;
          m_mem[i][m_clr_pos] = cv;
          m_rdv[i] = 0;
        end
        m_clr_pos++;
        m_clr_left--;
      end else if (clr) begin
        m_clr_left = 256;
        m_clr_pos = 0;
        for (int i = 0; i < 2; i++) m_rdv[i] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          a = m_mar[i];
          m_rdv[i] = 0;
          if (!mw) begin
            if (rd && !wr) begin
              m_rdv[i] = 1;
              m_rdd[i] = m_mem[i][a];
            end
            if (!ad && wr) m_mem[i][a] = bus;
            if (ad && cu) m_mar[i] = bus;
          end else if (rise) begin
            if (ad) m_mar[i] = fi;
            else begin
              m_mem[i][a] = fi;
              if (i == 0) m_mar[i] = a + 8'd1;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare both DUTs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_bus0",  cb0, m_rdv[0] ? m_rdd[0] : 8'h00);
    chk("m_bus1",  cb1, m_rdv[1] ? m_rdd[1] : 8'h00);
    chk("m_vld0",  rv0, m_rdv[0]);
    chk("m_vld1",  rv1, m_rdv[1]);
    chk("m_busy0", by0, m_clr_left > 0);
    chk("m_busy1", by1, m_clr_left > 0);
    chk("m_mar0",  mo0, m_mar[0]);
    chk("m_mar1",  mo1, m_mar[1]);
  endtask

  task automatic idle_in();
    rst = 0; mw = 0; ad = 0; cu = 0; wr = 0; rd = 0; st = 0; clr = 0;
    bus = 8'h00; fi = 8'h00;
  endtask

  task automatic read_at(input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1,
                         input string nm);
    idle_in(); ad = 1; cu = 1; bus = a; tick();
    idle_in(); rd = 1; tick();
    chk({nm, "_vld"}, rv0, 1'b1);
    chk({nm, "_d0"}, cb0, e0);
    chk({nm, "_d1"}, cb1, e1);
    idle_in();
  endtask

  task automatic fill_xor();
    for (int a = 0; a < 256; a++) begin
      idle_in(); ad = 1; cu = 1; bus = 8'(a); tick();
      idle_in(); wr = 1; bus = 8'(a) ^ 8'hFF; tick();
    end
    idle_in();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       mw, ad, cu, wr, rd, st;
    logic [7:0] bus, fi;
    bit         chk;
    logic [7:0] e_bus;
    logic       e_vld;
    logic [7:0] e_mar0, e_mar1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t V(logic m, logic a, logic c, logic w, logic r, logic s,
                             logic [7:0] b, logic [7:0] f, bit k,
                             logic [7:0] eb, logic ev, logic [7:0] e0, logic [7:0] e1);
    vec_t v;
    v.mw = m; v.ad = a; v.cu = c; v.wr = w; v.rd = r; v.st = s;
    v.bus = b; v.fi = f; v.chk = k;
    v.e_bus = eb; v.e_vld = ev; v.e_mar0 = e0; v.e_mar1 = e1;
    return v;
  endfunction

  initial begin
    int         n;
    logic [7:0] dv [3];

    // Test 1: CPU write/read at 0x3C
    vq.push_back(V(0,1,1,0,0,0, 8'h3C,8'h00, 1, 8'h00,0, 8'h3C,8'h3C));
    vq.push_back(V(0,0,0,1,0,0, 8'hA5,8'h00, 1, 8'h00,0, 8'h3C,8'h3C));
    vq.push_back(V(0,0,0,0,1,0, 8'h00,8'h00, 1, 8'hA5,1, 8'h3C,8'h3C));
    vq.push_back(V(0,0,0,0,0,0, 8'h00,8'h00, 1, 8'h00,0, 8'h3C,8'h3C));
    // Test 2: manual entry, ST held 5 cycles per store
    vq.push_back(V(1,1,0,0,0,1, 8'h00,8'h10, 1, 8'h00,0, 8'h10,8'h10));
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      vq.push_back(V(1,0,0,0,0,0, 8'h00,dv[k], 1, 8'h00,0, 8'(8'h10 + k),8'h10));
      for (int h = 0; h < 5; h++)
        vq.push_back(V(1,0,0,0,0,1, 8'h00,dv[k], 1, 8'h00,0, 8'(8'h11 + k),8'h10));
    end
    vq.push_back(V(1,0,0,0,0,0, 8'h00,8'h00, 1, 8'h00,0, 8'h13,8'h10));
    for (int k = 0; k < 3; k++) begin
      vq.push_back(V(0,1,1,0,0,0, 8'(8'h10 + k),8'h00, 1, 8'h00,0, 8'(8'h10 + k),8'(8'h10 + k)));
      vq.push_back(V(0,0,0,0,1,0, 8'h00,8'h00, 1, dv[k],1, 8'(8'h10 + k),8'(8'h10 + k)));
    end
    // Test 3: wrap at 0xFF (u0 auto-increments, u1 does not)
    vq.push_back(V(1,1,0,0,0,1, 8'h00,8'hFF, 1, 8'h00,0, 8'hFF,8'hFF));
    vq.push_back(V(1,0,0,0,0,0, 8'h00,8'h5A, 1, 8'h00,0, 8'hFF,8'hFF));
    vq.push_back(V(1,0,0,0,0,1, 8'h00,8'h5A, 1, 8'h00,0, 8'h00,8'hFF));
    vq.push_back(V(1,0,0,0,0,0, 8'h00,8'h00, 0, 8'h00,0, 8'h00,8'h00));
    vq.push_back(V(0,1,1,0,0,0, 8'hFF,8'h00, 1, 8'h00,0, 8'hFF,8'hFF));
    vq.push_back(V(0,0,0,0,1,0, 8'h00,8'h00, 1, 8'h5A,1, 8'hFF,8'hFF));
    // Test 6: RD & WR conflict
    vq.push_back(V(0,1,1,0,0,0, 8'h20,8'h00, 1, 8'h00,0, 8'h20,8'h20));
    vq.push_back(V(0,0,0,1,1,0, 8'h99,8'h00, 1, 8'h00,0, 8'h20,8'h20));
    vq.push_back(V(0,0,0,0,1,0, 8'h00,8'h00, 1, 8'h99,1, 8'h20,8'h20));
    vq.push_back(V(0,0,0,0,0,0, 8'h00,8'h00, 1, 8'h00,0, 8'h20,8'h20));

    // Reset and reset-state checks
    idle_in(); rst = 1;
    m_stq = 0; m_clr_left = 0; m_clr_pos = 0;
    for (int i = 0; i < 2; i++) begin m_mar[i] = 0; m_rdv[i] = 0; m_rdd[i] = 0; end
    tick(); tick();
    chk("rst_bus",  cb0, 8'h00);
    chk("rst_vld",  rv0, 1'b0);
    chk("rst_busy", by0, 1'b0);
    chk("rst_mar",  mo0, 8'h00);

    // Initial clear so every location holds a known value
    idle_in(); clr = 1; tick(); idle_in();
    n = 0;
    while (by0 && n < 300) begin n++; tick(); end
    chk("init_clear_len", n, 256);

    foreach (vq[i]) begin
      mw = vq[i].mw; ad = vq[i].ad; cu = vq[i].cu; wr = vq[i].wr; rd = vq[i].rd;
      st = vq[i].st; bus = vq[i].bus; fi = vq[i].fi; rst = 0; clr = 0;
      tick();
      if (vq[i].chk) begin
        chk($sformatf("vec%0d_bus", i),  cb0, vq[i].e_bus);
        chk($sformatf("vec%0d_vld", i),  rv0, vq[i].e_vld);
        chk($sformatf("vec%0d_mar0", i), mo0, vq[i].e_mar0);
        chk($sformatf("vec%0d_mar1", i), mo1, vq[i].e_mar1);
      end
    end
    read_at(8'h10, 8'h11, 8'h33, "man_mem10");

    // Test 4: clear with traffic during busy
    fill_xor();
    read_at(8'h7F, 8'h80, 8'h80, "prefill_7f");
    clr = 1; tick();
    chk("clr_busy_start", by0, 1'b1);
    n = 0;
    while (by0 && n < 300) begin
      n++;
      idle_in();
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      ad = 1'($urandom_range(0, 1)); cu = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0); bus = 8'hEE;
      tick();
    end
    chk("clr_busy_len", n, 256);
    idle_in();
    read_at(8'h00, 8'h00, 8'hC3, "clr_rd00");
    read_at(8'h7F, 8'h00, 8'hC3, "clr_rd7f");
    read_at(8'hFF, 8'h00, 8'hC3, "clr_rdff");

    // Test 5: reset mid-clear when cnt reaches 0x40
    fill_xor();
    clr = 1; tick(); idle_in();
    for (int k = 0; k < 8'h40; k++) tick();
    rst = 1; tick(); rst = 0;
    chk("rstclr_busy0", by0, 1'b0);
    chk("rstclr_busy1", by1, 1'b0);
    chk("rstclr_mar",   mo0, 8'h00);
    read_at(8'h3F, 8'h00, 8'hC3, "rstclr_3f");
    read_at(8'h40, 8'hBF, 8'hBF, "rstclr_40");
    read_at(8'h80, 8'h7F, 8'h7F, "rstclr_80");

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      clr = ($urandom_range(0, 399) == 0);
      mw  = 1'($urandom_range(0, 1));
      ad  = 1'($urandom_range(0, 1));
      cu  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 2) == 0) ? ~st : st;
      bus = 8'($urandom);
      fi  = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
